instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch and issue unit for the lab MIPS processor. It holds the program counter, fetches one 32-bit word at a time from instruction memory over a request/acknowledge handshake, and latches it into an instruction register. It drives `op_code` and the other instruction fields into the `control` decoder and the datapath, then takes the branch outcome back to select the next PC. It is the producer side of the `op_code` interface that `control` consumes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the word being fetched; equals PC.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `stall`  in  1  datapath not ready to retire the issued instruction.
- `branch`  in  1  `Branch` output of `control` for the issued instruction.
- `zero`  in  1  ALU zero flag for the issued instruction.
- `instr_valid`  out  1  instruction register holds an instruction being issued.
- `op_code`  out  6  IR[31:26], to `control`.
- `rs`  out  5  IR[25:21].
- `rt`  out  5  IR[20:16].
- `rd`  out  5  IR[15:11].
- `funct`  out  6  IR[5:0].
- `imm`  out  16  IR[15:0].
- `pc_plus4`  out  32  PC + 4 for the issued instruction.

## Operation
- Two-state FSM: FETCH, ISSUE. Reset state: FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=PC, both held stable until ack.
  - On `imem_ack`=1, IR <= `imem_rdata` and the FSM goes to ISSUE.
  - With `imem_ack`=0 the FSM stays in FETCH with PC unchanged.
- ISSUE:
  - `instr_valid`=1 and `imem_req`=0; the field outputs decode IR combinationally.
  - `stall`=1: hold ISSUE; PC and IR are unchanged.
  - `stall`=0: update PC and go to FETCH.
    - If `branch` and `zero` are both 1, PC <= PC + 4 + (sign_extend(`imm`) << 2).
    - Otherwise, PC <= PC + 4.
- Arithmetic:
  - PC arithmetic is 32-bit unsigned and wraps modulo 2^32 (PC=32'hFFFF_FFFC gives `pc_plus4`=0).
  - PC[1:0] is always 0.
- `imem_ack` is ignored outside FETCH.
- `branch` and `zero` are ignored outside ISSUE, and are ignored while `stall`=1.
- Field outputs are pure slices of IR. They hold the last instruction while the FSM is in FETCH; `instr_valid` qualifies them.

## Timing
- Reset values:
  - PC=`RESET_PC` and IR=0, so `op_code`, `rs`, `rt`, `rd`, `funct` and `imm` are all 0.
  - `imem_req`=1 (FETCH) and `imem_addr`=`RESET_PC`.
  - `instr_valid`=0 and `pc_plus4`=`RESET_PC`+4.
- `rst` overrides every other input, including an ack or an issue in the same cycle. Reset during a pending fetch abandons it; memory must tolerate the request address changing.
- Zero-wait memory: an ack in the first FETCH cycle gives a throughput of 2 cycles per instruction (FETCH, ISSUE).
- Latency: `instr_valid` rises on the cycle after the ack edge.
- After the ISSUE exit edge, the next `imem_addr` already reflects the branch decision; there is no delay slot.
- `stall` is sampled every ISSUE cycle. Issue length is 1 + (number of cycles with `stall`=1).

## Configuration
- `FETCH_JUMP_EN` defined:
  - `op_code`=6'd2 (J) in ISSUE with `stall`=0 sets PC <= {PC+4[31:28], IR[25:0], 2'b00}.
  - The jump takes priority over `branch`/`zero`.
- `FETCH_JUMP_EN` undefined: opcode 2 is treated as any non-branch instruction (PC <= PC + 4). No jump logic is synthesized.

## Test plan
- Reset, then zero-wait memory returning 32'h8C00_0000 (lw) → `imem_addr`=0; on the next cycle `instr_valid`=1 and `op_code`=35; next `imem_addr`=4.
- Memory acks after 3 wait cycles → `imem_req` and `imem_addr` are held for 4 cycles; `instr_valid` stays 0 until the cycle after the ack.
- Fetch beq 32'h1000_0003 at PC=8 with `branch`=1, `zero`=1 → next `imem_addr`=24. Repeat with `zero`=0 → next `imem_addr`=12. Repeat with `imm`=16'hFFFF and `zero`=1 → next `imem_addr`=8.
- Fetch sw (`op_code`=43) with `stall`=1 for 2 cycles → `instr_valid` is high for 3 cycles; `imem_req` stays 0 and PC does not advance until `stall`=0.
- Assert `rst` mid-fetch (PC=16) and again during ISSUE with `stall`=1 → next cycle PC=`RESET_PC`, `instr_valid`=0, `op_code`=0.
- `FETCH_JUMP_EN` defined: J 32'h0800_0010 at PC=0 → next `imem_addr`=32'h40. Without the macro → next `imem_addr`=4.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction-memory fetch handshake and
// instruction register for the lab MIPS core. Two-state FSM (FETCH, ISSUE).
// Optional build macro FETCH_JUMP_EN adds J-type (opcode 2) jump handling;
// without it opcode 2 simply advances the PC by 4.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  output logic        instr_valid,
  output logic [5:0]  op_code,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [31:0] pc_plus4
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  // Taken-branch target: PC+4 plus the sign-extended word offset.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] off);
    logic signed [31:0] disp;
    disp = {{14{off[15]}}, off, 2'b00};
    return pc4 + disp;
  endfunction

`ifdef FETCH_JUMP_EN
  // J-type target: top nibble of PC+4 with the 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction
`endif

  assign pc_plus4    = pc_q + 32'd4;
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);

  // Field outputs are plain slices of the instruction register.
  assign op_code = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm     = ir_q[15:0];

  // Next-state, next-PC and instruction-register load selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          state_d = FETCH;
          if (branch && zero) begin
            pc_d = branch_target(pc_plus4, ir_q[15:0]);
          end else begin
            pc_d = pc_plus4;
          end
`ifdef FETCH_JUMP_EN
          // Jump overrides any branch decision for the same instruction.
          if (ir_q[31:26] == 6'd2) begin
            pc_d = jump_target(pc_plus4, ir_q[25:0]);
          end
`endif
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State, PC and IR registers; reset abandons any pending fetch or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[31:2], 2'b00};
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        instr_valid;
  logic [5:0]  op_code;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc_plus4;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mpc;   // reference program counter

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch(branch), .zero(zero),
    .instr_valid(instr_valid), .op_code(op_code),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
    .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural next PC for a retired instruction.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                          input logic br, input logic z);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(w[15:0])) * 4;
`ifdef FETCH_JUMP_EN
    if (w[31:26] == 6'd2) return {seq[31:28], w[25:0], 2'b00};
`endif
    if (br && z) return seq + 32'(off);
    return seq;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, ".req"}, 32'(imem_req), 32'd1);
    chk({tag, ".addr"}, imem_addr, RPC);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".op"}, 32'(op_code), 32'd0);
    chk({tag, ".rs"}, 32'(rs), 32'd0);
    chk({tag, ".rt"}, 32'(rt), 32'd0);
    chk({tag, ".rd"}, 32'(rd), 32'd0);
    chk({tag, ".funct"}, 32'(funct), 32'd0);
    chk({tag, ".imm"}, 32'(imm), 32'd0);
    chk({tag, ".pc4"}, pc_plus4, RPC + 32'd4);
  endtask

  // One full instruction: fetch with `waits` idle cycles, then issue with
  // `stalls` stalled cycles, retiring with the given branch/zero. Called and
  // returning at a falling edge.
  task automatic run_instr(input logic [31:0] w, input int waits, input int stalls,
                           input logic br, input logic z);
    for (int i = 0; i <= waits; i++) begin
      chk("fetch.req", 32'(imem_req), 32'd1);
      chk("fetch.addr", imem_addr, mpc);
      chk("fetch.valid", 32'(instr_valid), 32'd0);
      imem_ack   = (i == waits);
      imem_rdata = (i == waits) ? w : $urandom;
      stall      = $urandom_range(0, 1);
      branch     = $urandom_range(0, 1);
      zero       = $urandom_range(0, 1);
      @(negedge clk);
    end
    for (int j = 0; j <= stalls; j++) begin
      chk("issue.valid", 32'(instr_valid), 32'd1);
      chk("issue.req", 32'(imem_req), 32'd0);
      chk("issue.addr", imem_addr, mpc);
      chk("issue.op", 32'(op_code), 32'(w[31:26]));
      chk("issue.rs", 32'(rs), 32'(w[25:21]));
      chk("issue.rt", 32'(rt), 32'(w[20:16]));
      chk("issue.rd", 32'(rd), 32'(w[15:11]));
      chk("issue.funct", 32'(funct), 32'(w[5:0]));
      chk("issue.imm", 32'(imm), 32'(w[15:0]));
      chk("issue.pc4", pc_plus4, mpc + 32'd4);
      imem_ack   = $urandom_range(0, 1);
      imem_rdata = $urandom;
      stall      = (j < stalls);
      branch     = (j < stalls) ? 1'($urandom_range(0, 1)) : br;
      zero       = (j < stalls) ? 1'($urandom_range(0, 1)) : z;
      @(negedge clk);
    end
    mpc = next_pc(mpc, w, br, z);
    imem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] off;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; branch = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    mpc = RPC;

    // lw with zero-wait memory, then a 3-wait fetch
    run_instr(32'h8C00_0000, 0, 0, 1'b0, 1'b0);
    chk("lw.next_addr", imem_addr, 32'd4);
    run_instr(32'h0123_4820, 3, 0, 1'b0, 1'b0);
    chk("wait.next_addr", imem_addr, 32'd8);

    // beq taken / not taken / backward
    run_instr(32'h1000_0003, 0, 0, 1'b1, 1'b1);
    chk("beq.taken", imem_addr, 32'd24);
    run_instr(32'h1000_FFFB, 1, 0, 1'b1, 1'b1);
    chk("beq.back8", imem_addr, 32'd8);
    run_instr(32'h1000_0003, 0, 0, 1'b1, 1'b0);
    chk("beq.nottaken", imem_addr, 32'd12);
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1);
    run_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b1);
    chk("beq.self", imem_addr, 32'd8);

    // sw held in issue by two stall cycles
    run_instr(32'hAC00_0000, 0, 2, 1'b0, 1'b0);
    chk("sw.next_addr", imem_addr, 32'd12);

    // wrap: branch to 0xFFFFFFFC, then sequential wrap to 0
    run_instr(32'h1000_FFFB, 0, 0, 1'b1, 1'b1);
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0);
    chk("wrap.next", imem_addr, 32'h0);

    // J at PC 0
    run_instr(32'h0800_0010, 0, 0, 1'b0, 1'b0);
`ifdef FETCH_JUMP_EN
    chk("jump.addr", imem_addr, 32'h40);
`else
    chk("jump.addr", imem_addr, 32'h4);
`endif

    // steer to PC 16, then reset during a pending fetch
    off = 16'((32'd16 - (mpc + 32'd4)) >> 2);
    run_instr({16'h1000, off}, 0, 0, 1'b1, 1'b1);
    chk("pre_rst.addr", imem_addr, 32'd16);
    repeat (2) begin
      chk("pend.req", 32'(imem_req), 32'd1);
      imem_ack = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_reset("rst_fetch");
    rst = 1'b0; imem_ack = 1'b0;
    mpc = RPC;

    // reset during a stalled issue
    imem_ack = 1'b1; imem_rdata = 32'hAC00_0000;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("rst_iss.valid", 32'(instr_valid), 32'd1);
    stall = 1'b1;
    @(negedge clk);
    rst = 1'b1; branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    check_reset("rst_issue");
    rst = 1'b0; stall = 1'b0;

    // randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      w = $urandom;
      if (k % 5 == 0) w[31:26] = 6'd2;
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("final.addr", imem_addr, mpc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
